// File: rtl/neuron_mac.sv
// Single-neuron fixed-point multiply-accumulate: weight RAM, product/accumulate pipeline, bias add.
// Optional saturating arithmetic is enabled by defining NEURON_MAC_SAT_EN (wrap-around otherwise).
module neuron_mac #(
  parameter int dataWidth = 16,
  parameter int intWidth  = 4,
  parameter int numInputs = 784,
  parameter int addrWidth = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     w_wr_en,
  input  logic [addrWidth-1:0]     w_wr_addr,
  input  logic [dataWidth-1:0]     w_wr_data,
  input  logic                     bias_wr_en,
  input  logic [dataWidth-1:0]     bias_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [dataWidth-1:0]     in_data,
  output logic                     sum_valid,
  output logic [2*dataWidth-1:0]   sum_out,
  output logic                     busy
);

  localparam int fracWidth = dataWidth - 1 - intWidth;
  localparam int accWidth  = 2 * dataWidth;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, BIAS} state_t;

  state_t                      state_reg, state_next;
  logic [addrWidth-1:0]        in_cnt_reg;
  logic signed [accWidth-1:0]  prod_reg;
  logic                        prod_vld_reg;
  logic signed [accWidth-1:0]  acc_reg;
  logic                        done_reg;
  logic [dataWidth-1:0]        bias_reg;

  logic [dataWidth-1:0]        weight_mem [numInputs];
  logic [dataWidth-1:0]        weight_rd;
  logic signed [accWidth-1:0]  mult;
  logic signed [accWidth-1:0]  bias_ext;
  logic                        xfer;
  logic                        last_elem;

  function automatic logic signed [accWidth-1:0] acc_add(
    input logic signed [accWidth-1:0] a,
    input logic signed [accWidth-1:0] b
  );
`ifdef NEURON_MAC_SAT_EN
    logic signed [accWidth:0] s;
    s = {a[accWidth-1], a} + {b[accWidth-1], b};
    // Sign of the extended sum disagreeing with its top bit means the result left the range
    if (s[accWidth] != s[accWidth-1])
      return s[accWidth] ? {1'b1, {(accWidth-1){1'b0}}} : {1'b0, {(accWidth-1){1'b1}}};
    return s[accWidth-1:0];
`else
    return a + b;
`endif
  endfunction

  assign in_ready  = rst_n && (state_reg == IDLE || state_reg == ACC);
  assign xfer      = in_valid && in_ready;
  assign last_elem = (in_cnt_reg == addrWidth'(numInputs - 1));
  assign busy      = (in_cnt_reg != '0) || (state_reg != IDLE) || done_reg;

  // Combinational read: a same-cycle write to this address lands at the edge, so the old weight is used
  assign weight_rd = weight_mem[in_cnt_reg];
  assign mult      = accWidth'($signed(in_data)) * accWidth'($signed(weight_rd));
  assign bias_ext  = $signed({{dataWidth{bias_reg[dataWidth-1]}}, bias_reg}) <<< fracWidth;

  always_ff @(posedge clk) begin
    if (w_wr_en && !busy)
      weight_mem[w_wr_addr] <= w_wr_data;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (xfer) state_next = last_elem ? DRAIN : ACC;
      ACC:     if (xfer && last_elem) state_next = DRAIN;
      DRAIN:   state_next = BIAS;
      BIAS:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      in_cnt_reg   <= '0;
      prod_reg     <= '0;
      prod_vld_reg <= 1'b0;
      acc_reg      <= '0;
      done_reg     <= 1'b0;
      sum_out      <= '0;
      sum_valid    <= 1'b0;
      bias_reg     <= '0;
    end else begin
      state_reg <= state_next;

      if (xfer) begin
        in_cnt_reg <= last_elem ? '0 : in_cnt_reg + 1'b1;
        prod_reg   <= mult;
      end
      prod_vld_reg <= xfer;

      // Bias goes in once the last product has drained; a new vector clears the sum
      if (state_reg == BIAS)
        acc_reg <= acc_add(acc_reg, bias_ext);
      else if (state_reg == IDLE && xfer)
        acc_reg <= '0;
      else if (prod_vld_reg)
        acc_reg <= acc_add(acc_reg, prod_reg);

      done_reg  <= (state_reg == BIAS);
      sum_valid <= done_reg;
      if (done_reg)
        sum_out <= acc_reg;

      if (bias_wr_en && !busy)
        bias_reg <= bias_data;
    end
  end

endmodule
